serial_add_seq: RTL and testbench

Bit-serial add/subtract sequencer. It time-shares a single existing full_adder cell across all WIDTH bits of an operand pair, one bit per clock, LSB first. It is the low-area arithmetic option for the 32-bit RISC datapath, such as multi-cycle ALU ops or address calculation in the slow path. The block owns operand shift registers, the carry flip-flop, a bit counter and a start/ready/done handshake.

---
 rtl/serial_add_seq_pkg.sv | 14 +
 rtl/serial_add_seq_full_adder.sv | 18 +
 rtl/serial_add_seq.sv | 148 ++++++++++++++
 tb/tb_serial_add_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/serial_add_seq_pkg.sv
// serial_add_seq_pkg
// Shared definitions for the bit-serial add/subtract sequencer: FSM state
// encoding and the default operand width.
package serial_add_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_seq_full_adder.sv
// full_adder
// Single-bit full adder cell, the only arithmetic element on the sum path
// of serial_add_seq.
// Ports:
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq
// Bit-serial add/subtract sequencer. One full_adder is time-shared across
// all WIDTH bits, LSB first, one bit per clock.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, op_sub     : request (taken when ready=1), 0 = a+b, 1 = a-b
//   a, b              : operands, sampled with an accepted start
//   ready, done       : can accept start / one-cycle result-valid pulse
//   result            : sum or difference, held until the next completion
//   cout, overflow    : raw carry out of MSB, signed overflow
//   zero              : result == 0
//
// state  | meaning
// S_IDLE | waiting for start, ready=1
// S_RUN  | shifting one bit per cycle through the adder, ready=0
// S_DONE | outputs just updated, done=1, ready=1 (start accepted here too)
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB1 = CNT_W'(WIDTH - 2);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               c_msb_q, c_msb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               fa_s, fa_co;
    logic [WIDTH-1:0]   res_next;

    full_adder u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign res_next = {fa_s, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        c_msb_d  = c_msb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction as a + ~b + 1: invert b, seed carry with 1.
                    opa_d   = a;
                    opb_d   = op_sub ? ~b : b;
                    carry_d = op_sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                res_d   = res_next;
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                // Carry into the MSB position, needed for signed overflow.
                if (cnt_q == CNT_MSB1) begin
                    c_msb_d = fa_co;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    result_d = res_next;
                    cout_d   = fa_co;
                    ovf_d    = fa_co ^ c_msb_q;
                    zero_d   = (res_next == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c_msb_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            c_msb_q  <= c_msb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign ready    = (state_q != S_RUN);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic [31:0] a, b;
    logic        ready, done;
    logic [31:0] result;
    logic        cout, overflow, zero;

    int errors = 0;
    int checks = 0;

    serial_add_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents the request, which is taken at the next posedge.
    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic sub);
        start  = 1'b1;
        a      = av;
        b      = bv;
        op_sub = sub;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        op_sub = 1'($urandom_range(0, 1));
    endtask

    // Returns at the negedge where done is seen. n counts negedges after the
    // accept edge; negedge n lies in RUN cycle n-1, so a pulse on RUN cycle k
    // is driven at negedge k+1.
    task automatic wait_done(input int p1, input int p2, input logic [31:0] prev,
                             output int lat, output int rdy_bad, output int hold_bad);
        lat = -1; rdy_bad = 0; hold_bad = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = (n == p1 + 1) || (n == p2 + 1);
            if (done) begin
                lat = n;
                start = 1'b0;
                break;
            end
            if (ready) rdy_bad++;
            if (result !== prev) hold_bad++;
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sub, input logic [31:0] er, input logic ec,
                          input logic eo, input logic ez);
        int lat, rb, hb;
        logic [31:0] prev;
        prev = result;
        @(negedge clk);
        launch(av, bv, sub);
        wait_done(-10, -10, prev, lat, rb, hb);
        chk({tag, "_lat"}, lat, 33);
        chk({tag, "_busy"}, rb, 0);
        chk({tag, "_hold"}, hb, 0);
        chk({tag, "_res"}, result, er);
        chk({tag, "_flags"}, {29'd0, cout, overflow, zero}, {29'd0, ec, eo, ez});
        chk({tag, "_rdy_done"}, ready, 1);
    endtask

    initial begin
        int lat, rb, hb, dcnt;
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_outs", {result, cout, overflow, zero} == 35'd0, 1);
        rst = 1'b0;

        run_op("add",   32'd5,          32'd3, 1'b0, 32'd8,          1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_hold", result, 32'd8);
        run_op("wrap",  32'hFFFF_FFFF,  32'd1, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1);
        run_op("ovf",   32'h7FFF_FFFF,  32'd1, 1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0);
        run_op("subb",  32'd5,          32'd7, 1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0);
        run_op("sub",   32'd7,          32'd5, 1'b1, 32'd2,          1'b1, 1'b0, 1'b0);
        run_op("subneg",32'h8000_0000,  32'd1, 1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0);

        // Busy rejection, then back-to-back accept in the done cycle.
        @(negedge clk);
        launch(32'd1, 32'd1, 1'b0);
        a = 32'hDEAD; b = 32'hBEEF;
        wait_done(3, 20, 32'd2, lat, rb, hb);
        chk("busy_lat", lat, 33);
        chk("busy_ready", rb, 0);
        chk("busy_res", result, 32'd2);
        launch(32'd10, 32'd20, 1'b0);
        wait_done(-10, -10, 32'd2, lat, rb, hb);
        chk("b2b_lat", lat, 33);
        chk("b2b_res", result, 32'd30);
        chk("b2b_hold", hb, 0);

        // Reset in RUN cycle 10.
        @(negedge clk);
        launch(32'd100, 32'd200, 1'b0);
        dcnt = 0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_res", result, 32'd0);
        chk("mid_rst_flags", {29'd0, cout, overflow, zero}, 32'd0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("mid_rst_nodone", dcnt, 0);
        run_op("after_rst", 32'd100, 32'd200, 1'b0, 32'd300, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
